// File: rtl/md_sched.sv
// Multiply/divide scheduler for the EX stage: owns HI/LO, runs a fixed-latency
// busy window per MULT/MULTU/DIV/DIVU and raises the ID-stage stall.
module md_sched #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_valid,
    input  logic [2:0]  md_op,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    input  logic        id_md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [63:0] pend_q, pend_d;
    logic        pend_wr_q, pend_wr_d;
    logic        accept_start;

    function automatic logic [63:0] mul_s(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [63:0] ea, eb;
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of trapping.
    function automatic logic [63:0] div_s(input logic signed [31:0] a, input logic signed [31:0] b);
        logic [31:0] ua, ub, uq, ur, q, r;
        ua = a[31] ? 32'(-a) : 32'(a);
        ub = b[31] ? 32'(-b) : 32'(b);
        if (ub == 32'd0) return 64'd0;
        uq = ua / ub;
        ur = ua % ub;
        q  = (a[31] ^ b[31]) ? -uq : uq;
        r  = a[31] ? -ur : ur;
        return {r, q};
    endfunction

    function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 64'd0;
        return {a % b, a / b};
    endfunction

    always_comb begin
        accept_start = md_valid && (state_q == IDLE) &&
                       (md_op >= OP_MULT) && (md_op <= OP_DIVU);
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            IDLE: begin
                if (md_valid) begin
                    case (md_op)
                        OP_MULT: begin
                            pend_d = mul_s(md_a, md_b);
                            pend_wr_d = 1'b1;
                            cnt_d = 4'(MUL_CYCLES);
                            state_d = BUSY;
                        end
                        OP_MULTU: begin
                            pend_d = mul_u(md_a, md_b);
                            pend_wr_d = 1'b1;
                            cnt_d = 4'(MUL_CYCLES);
                            state_d = BUSY;
                        end
                        OP_DIV: begin
                            pend_d = div_s(md_a, md_b);
                            pend_wr_d = (md_b != 32'd0);
                            cnt_d = 4'(DIV_CYCLES);
                            state_d = BUSY;
                        end
                        OP_DIVU: begin
                            pend_d = div_u(md_a, md_b);
                            pend_wr_d = (md_b != 32'd0);
                            cnt_d = 4'(DIV_CYCLES);
                            state_d = BUSY;
                        end
                        OP_MTHI: hi_d = md_a;
                        OP_MTLO: lo_d = md_a;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                // A zero divisor runs the full window but leaves HI/LO untouched.
                if (cnt_q <= 4'd1) begin
                    if (pend_wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_q <= pend_d;
    end

    assign busy  = (state_q == BUSY);
    assign stall = id_md_use & (busy | accept_start);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: busy window length, HI/LO results, stall and reset abort.
module tb_md_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        md_valid;
    logic [2:0]  md_op;
    logic [31:0] md_a, md_b;
    logic        id_md_use;
    logic        busy, stall;
    logic [31:0] hi, lo;
    logic        busy1, stall1;
    logic [31:0] hi1, lo1;

    int n_cmp = 0;
    int n_err = 0;

    md_sched #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .md_valid(md_valid), .md_op(md_op),
        .md_a(md_a), .md_b(md_b), .id_md_use(id_md_use),
        .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    md_sched #(.MUL_CYCLES(1), .DIV_CYCLES(10)) dut1 (
        .clk(clk), .reset(reset), .md_valid(md_valid), .md_op(md_op),
        .md_a(md_a), .md_b(md_b), .id_md_use(id_md_use),
        .busy(busy1), .stall(stall1), .hi(hi1), .lo(lo1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md_valid = 1'b1;
        md_op    = op;
        md_a     = a;
        md_b     = b;
        step();
        md_valid = 1'b0;
        md_op    = 3'd0;
    endtask

    // Counts busy cycles from the current one until busy drops (bounded).
    task automatic wait_idle(input string tag, input int exp_n);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            step();
        end
        chk(tag, 32'(n), 32'(exp_n));
    endtask

    initial begin
        reset = 1'b1; md_valid = 1'b0; md_op = 3'd0;
        md_a = 32'd0; md_b = 32'd0; id_md_use = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        reset = 1'b0;
        id_md_use = 1'b1;
        #1;
        chk("idle_stall", 32'(stall), 32'd0);
        id_md_use = 1'b0;

        // 1: MULT / MULTU of -2 and 3
        start(3'd1, 32'hFFFF_FFFE, 32'd3);
        chk("mult_hi_held", hi, 32'd0);
        wait_idle("mult_busy_n", 5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        start(3'd2, 32'hFFFF_FFFE, 32'd3);
        wait_idle("multu_busy_n", 5);
        chk("multu_hi", hi, 32'h0000_0002);
        chk("multu_lo", lo, 32'hFFFF_FFFA);

        // 2: DIV -7/2, DIVU 7/2, signed overflow
        start(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle("div_busy_n", 10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        start(3'd4, 32'd7, 32'd2);
        wait_idle("divu_busy_n", 10);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);
        start(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("dovf_busy_n", 10);
        chk("dovf_lo", lo, 32'h8000_0000);
        chk("dovf_hi", hi, 32'd0);

        // 3: MTHI/MTLO preload, no-op codes, divide by zero
        start(3'd5, 32'h11, 32'd0);
        chk("mthi_hi", hi, 32'h11);
        chk("mthi_busy", 32'(busy), 32'd0);
        start(3'd6, 32'h22, 32'd0);
        chk("mtlo_lo", lo, 32'h22);
        chk("mtlo_busy", 32'(busy), 32'd0);
        start(3'd7, 32'h99, 32'd1);
        chk("op7_busy", 32'(busy), 32'd0);
        chk("op7_hi", hi, 32'h11);
        start(3'd0, 32'h99, 32'd1);
        chk("op0_lo", lo, 32'h22);
        start(3'd3, 32'd123, 32'd0);
        wait_idle("dz_busy_n", 10);
        chk("dz_hi", hi, 32'h11);
        chk("dz_lo", lo, 32'h22);

        // 4: stall across accept and busy window; ignored request mid-busy
        id_md_use = 1'b1;
        md_valid = 1'b1; md_op = 3'd1; md_a = 32'd3; md_b = 32'd5;
        #1;
        chk("st_accept", 32'(stall), 32'd1);
        chk("st_accept_busy", 32'(busy), 32'd0);
        step();
        md_valid = 1'b0; md_op = 3'd0;
        for (int i = 0; i < 5; i++) begin
            chk("st_busy", 32'(busy), 32'd1);
            chk("st_stall", 32'(stall), 32'd1);
            if (i == 2) begin
                md_valid = 1'b1; md_op = 3'd1; md_a = 32'd7; md_b = 32'd7;
            end
            step();
            md_valid = 1'b0; md_op = 3'd0;
        end
        chk("st_fall_busy", 32'(busy), 32'd0);
        chk("st_fall_stall", 32'(stall), 32'd0);
        chk("st_lo", lo, 32'd15);
        chk("st_hi", hi, 32'd0);
        id_md_use = 1'b0;

        // 5: reset in cycle 3 of a DIV, with a simultaneous MTHI
        start(3'd3, 32'd100, 32'd7);
        step();
        step();
        reset = 1'b1;
        md_valid = 1'b1; md_op = 3'd5; md_a = 32'h55;
        step();
        reset = 1'b0; md_valid = 1'b0; md_op = 3'd0;
        chk("ra_busy", 32'(busy), 32'd0);
        chk("ra_hi", hi, 32'd0);
        chk("ra_lo", lo, 32'd0);
        repeat (12) step();
        chk("ra_discard_lo", lo, 32'd0);
        start(3'd4, 32'd9, 32'd4);
        wait_idle("ra_divu_n", 10);
        chk("ra_divu_lo", lo, 32'd2);
        chk("ra_divu_hi", hi, 32'd1);

        // 6: back-to-back MULT then DIV, then MUL_CYCLES=1 instance
        start(3'd1, 32'd6, 32'd7);
        wait_idle("b2b_mult_n", 5);
        chk("b2b_mult_lo", lo, 32'd42);
        start(3'd3, 32'd100, 32'd7);
        wait_idle("b2b_div_n", 10);
        chk("b2b_div_lo", lo, 32'd14);
        chk("b2b_div_hi", hi, 32'd2);

        reset = 1'b1;
        step();
        reset = 1'b0;
        start(3'd1, 32'd5, 32'd5);
        chk("m1_busy", 32'(busy1), 32'd1);
        step();
        chk("m1_fall", 32'(busy1), 32'd0);
        chk("m1_lo", lo1, 32'd25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
